// File: rtl/mul_result_fifo_bf16.sv
// mul_result_fifo_bf16
// Collector for the bf16 multiplier pipeline. It captures results without
// stalling, holds them in a first-word-fall-through FIFO and offers them to
// the consumer over valid/ready. Credit accounting (count + in_flight) keeps a
// compliant issuer from launching a multiply whose result would find the FIFO
// full.
// Optional feature: define MUL_RESULT_NAN_COUNT_EN to build the saturating
// counter of accepted NaN results. Otherwise nan_count is tied to zero.
module mul_result_fifo_bf16 #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  output logic             can_issue,
  input  logic [15:0]      z_in,
  input  logic             z_in_stb,
  output logic [15:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [AW:0]      count,
  output logic [AW:0]      in_flight,
  output logic             overflow,
  output logic             protocol_err,
  output logic [CNT_W-1:0] nan_count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // Storage is deliberately left out of reset so it can map onto plain RAM.
  logic [15:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic [AW:0]   in_flight_reg, in_flight_next;
  logic          overflow_reg, overflow_next;
  logic          protocol_err_reg, protocol_err_next;

  logic          rd_en;
  logic          wr_en;
  logic [AW+1:0] credit_sum;

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign rd_en = m_valid && m_ready;
  assign wr_en = z_in_stb && ((count_reg != FULL) || rd_en);

  // Credits come from registered state only, so there is no path from
  // m_ready or issue into can_issue.
  assign credit_sum = {1'b0, count_reg} + {1'b0, in_flight_reg};
  assign can_issue  = credit_sum < {1'b0, FULL};

  assign m_valid      = (count_reg != '0);
  assign m_data       = m_valid ? mem[rd_ptr_reg] : 16'h0000;
  assign count        = count_reg;
  assign in_flight    = in_flight_reg;
  assign overflow     = overflow_reg;
  assign protocol_err = protocol_err_reg;

  // Next-state logic for pointers, occupancy, credits and sticky flags.
  always_comb begin
    wr_ptr_next       = wr_ptr_reg;
    rd_ptr_next       = rd_ptr_reg;
    count_next        = count_reg;
    in_flight_next    = in_flight_reg;
    overflow_next     = overflow_reg;
    protocol_err_next = protocol_err_reg;

    if (wr_en) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (rd_en) rd_ptr_next = rd_ptr_reg + AW'(1);

    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase

    // Issue and return in the same cycle cancel. A return with nothing
    // outstanding keeps the credit count at zero. Over-issue saturates.
    case ({issue, z_in_stb})
      2'b10: if (in_flight_reg != FULL) in_flight_next = in_flight_reg + (AW+1)'(1);
      2'b01: if (in_flight_reg != '0)   in_flight_next = in_flight_reg - (AW+1)'(1);
      default: in_flight_next = in_flight_reg;
    endcase

    if (z_in_stb && !wr_en) overflow_next = 1'b1;
    if ((issue && !can_issue) || (z_in_stb && (in_flight_reg == '0)))
      protocol_err_next = 1'b1;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      in_flight_reg    <= '0;
      overflow_reg     <= 1'b0;
      protocol_err_reg <= 1'b0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      in_flight_reg    <= in_flight_next;
      overflow_reg     <= overflow_next;
      protocol_err_reg <= protocol_err_next;
    end
  end

  // Result storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= z_in;
  end

`ifdef MUL_RESULT_NAN_COUNT_EN
  logic             is_nan;
  logic [CNT_W-1:0] nan_count_reg;

  // NaN: all-ones exponent with a non-zero mantissa. Infinity is excluded.
  assign is_nan    = (&z_in[14:7]) && (|z_in[6:0]);
  assign nan_count = nan_count_reg;

  // Saturating count of NaNs that were actually stored. Dropped words do not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_count_reg <= '0;
    end else if (wr_en && is_nan && (nan_count_reg != '1)) begin
      nan_count_reg <= nan_count_reg + CNT_W'(1);
    end
  end
`else
  assign nan_count = '0;
`endif

endmodule

// File: tb/tb_mul_result_fifo_bf16.sv
// Testbench for mul_result_fifo_bf16: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_mul_result_fifo_bf16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             issue = 1'b0;
  logic             can_issue;
  logic [15:0]      z_in = 16'h0000;
  logic             z_in_stb = 1'b0;
  logic [15:0]      m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [AW:0]      count;
  logic [AW:0]      in_flight;
  logic             overflow;
  logic             protocol_err;
  logic [CNT_W-1:0] nan_count;

  mul_result_fifo_bf16 #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .issue(issue), .can_issue(can_issue),
    .z_in(z_in), .z_in_stb(z_in_stb), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .count(count), .in_flight(in_flight),
    .overflow(overflow), .protocol_err(protocol_err), .nan_count(nan_count)
  );

  always #5 clk = ~clk;

  // Reference model: stored words, outstanding multiplies, sticky flags.
  logic [15:0] q[$];
  int          m_inf;
  bit          m_ovf;
  bit          m_perr;
  int          m_nan;

  int checks = 0;
  int passed = 0;
  int step_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (step %0d)", tag, obs, exp, step_no);
  endtask

  function automatic bit is_nan(input logic [15:0] w);
    return (w[14:7] == 8'hFF) && (w[6:0] != 7'h0);
  endfunction

  task automatic model_reset();
    q.delete();
    m_inf  = 0;
    m_ovf  = 0;
    m_perr = 0;
    m_nan  = 0;
  endtask

  // Compare every output against the model's current state.
  task automatic check_outputs();
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("m_data", 32'(m_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk("count", 32'(count), 32'(q.size()));
    chk("in_flight", 32'(in_flight), 32'(m_inf));
    chk("can_issue", 32'(can_issue), 32'((q.size() + m_inf) < DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("protocol_err", 32'(protocol_err), 32'(m_perr));
    chk("nan_count", 32'(nan_count), 32'(m_nan));
  endtask

  // One clock cycle: drive inputs, check state, then advance the model.
  task automatic step(input bit iss, input bit stb, input logic [15:0] z, input bit rdy);
    bit rd, wr, ci;
    @(negedge clk);
    issue = iss; z_in_stb = stb; z_in = z; m_ready = rdy;
    #1;
    step_no++;
    check_outputs();
    $display("step %0d issue=%b stb=%b z=%h rdy=%b count=%0d in_flight=%0d head=%h",
             step_no, iss, stb, z, rdy, count, in_flight, m_data);
    ci = (q.size() + m_inf) < DEPTH;
    rd = (q.size() != 0) && rdy;
    wr = stb && ((q.size() < DEPTH) || rd);
    @(posedge clk);
    if ((iss && !ci) || (stb && m_inf == 0)) m_perr = 1;
    if (stb && !wr) m_ovf = 1;
`ifdef MUL_RESULT_NAN_COUNT_EN
    if (wr && is_nan(z) && m_nan < (1 << CNT_W) - 1) m_nan++;
`endif
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(z);
    if (iss && !stb) m_inf = (m_inf < DEPTH) ? m_inf + 1 : DEPTH;
    else if (stb && !iss && m_inf > 0) m_inf--;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst = 1'b1; issue = 0; z_in_stb = 0; m_ready = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [15:0] vals [8];
  logic [15:0] pipe [$];
  logic [15:0] z;
  bit iss_r, stb_r, rdy_r;

  initial begin
    vals[0] = 16'h3F80; vals[1] = 16'h4000; vals[2] = 16'h4040; vals[3] = 16'h4080;
    vals[4] = 16'h40A0; vals[5] = 16'h40C0; vals[6] = 16'h40E0; vals[7] = 16'h4100;
    model_reset();

    // Reset state while rst is held.
    #3;
    check_outputs();
    chk("reset_m_data", 32'(m_data), 32'h0);
    chk("reset_can_issue", 32'(can_issue), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // 1: single multiply with 3-cycle latency, then consume.
    step(1, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    step(0, 1, 16'h40C0, 0);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);

    // 2: fill to DEPTH across the pointer wrap, issuing while allowed.
    for (int i = 0; i < 12; i++) begin
      step((i < 8) ? 1'b1 : 1'b0, (i >= 3 && i < 11) ? 1'b1 : 1'b0,
           (i >= 3 && i < 11) ? vals[i-3] : 16'h0, 0);
    end
    chk("full_count", 32'(count), 32'd8);
    chk("full_no_overflow", 32'(overflow), 32'h0);

    // 3: write and read together while full.
    step(0, 1, 16'h4040, 1);
    chk("full_rw_count", 32'(count), 32'd8);
    chk("full_rw_overflow", 32'(overflow), 32'h0);

    // 4: unsolicited write while full and not reading is dropped.
    step(0, 1, 16'hBEEF, 0);
    step(0, 0, 16'h0, 0);
    chk("drop_overflow", 32'(overflow), 32'h1);
    chk("drop_count", 32'(count), 32'd8);

    // Drain everything; the model checks order including the last 16'h4040.
    for (int i = 0; i < 9; i++) step(0, 0, 16'h0, 1);

    // 5: same-cycle issue and return, then asynchronous reset.
    sync_reset();
    step(1, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
    step(1, 1, 16'h3F80, 0);
    step(0, 0, 16'h0, 0);
    chk("issue_ret_inflight", 32'(in_flight), 32'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("async_can_issue", 32'(can_issue), 32'h1);
    #1 rst = 1'b0;

    // Post-reset return is unsolicited.
    step(0, 1, 16'h4000, 0);
    step(0, 0, 16'h0, 1);
    sync_reset();

    // 6: NaN / infinity mix.
    step(1, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
    step(0, 1, 16'hFFC0, 0);
    step(0, 1, 16'h7F80, 0);
    step(0, 1, 16'hFFC0, 0);
    step(0, 0, 16'h0, 0);
`ifdef MUL_RESULT_NAN_COUNT_EN
    chk("nan_count_2", 32'(nan_count), 32'd2);
`else
    chk("nan_count_0", 32'(nan_count), 32'd0);
`endif

    // Random traffic with a compliant issuer and fixed 3-cycle latency:
    // overflow and protocol_err must never set.
    sync_reset();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(16'h0);
    for (int i = 0; i < 300; i++) begin
      iss_r = ($urandom_range(0, 1) == 1) && ((q.size() + m_inf) < DEPTH);
      z     = pipe.pop_front();
      stb_r = (z != 16'h0);
      rdy_r = ($urandom_range(0, 3) == 0);
      pipe.push_back(iss_r ? (($urandom_range(0, 4) == 0) ? 16'hFF81 : 16'(($urandom | 32'h1) & 32'hFFFF)) : 16'h0);
      step(iss_r, stb_r, z, rdy_r);
    end
    chk("compliant_overflow", 32'(overflow), 32'h0);
    chk("compliant_perr", 32'(protocol_err), 32'h0);

    // Unconstrained random traffic, including misuse.
    for (int i = 0; i < 300; i++) begin
      iss_r = $urandom_range(0, 1);
      stb_r = $urandom_range(0, 2) == 0;
      rdy_r = $urandom_range(0, 3) == 0;
      z     = ($urandom_range(0, 3) == 0) ? 16'h7FC1 : 16'($urandom & 32'hFFFF);
      step(iss_r, stb_r, z, rdy_r);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mul_result_fifo_bf16.md
Name: mul_result_fifo_bf16

Overview:
Downstream collector for the 3-stage bf16 multiplier pipeline in the product-node datapath.
- Captures every result word the multiplier emits on its output strobe. The multiplier has no backpressure, so the capture cannot stall.
- Buffers results in a first-word-fall-through FIFO and presents them to the consumer over valid/ready.
- Runs credit accounting so the upstream issuer never launches a multiply whose result would find the FIFO full.

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2 and at least 4.
AW, 3, log2(DEPTH); pointer width.
CNT_W, 8, width of the NaN counter (optional feature only).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
issue  input  1  one-cycle pulse, asserted in the same cycle the issuer raises the multiplier input strobe.
can_issue  output  1  high when one more multiply may be launched this cycle.
z_in  input  16  bf16 result from the multiplier.
z_in_stb  input  1  multiplier output-valid; z_in is valid this cycle.
m_data  output  16  head-of-FIFO bf16 word.
m_valid  output  1  FIFO non-empty.
m_ready  input  1  consumer accepts m_data this cycle.
count  output  AW+1  entries currently stored, 0..DEPTH.
in_flight  output  AW+1  multiplies issued but not yet returned, 0..DEPTH.
overflow  output  1  sticky; a result was dropped because the FIFO was full.
protocol_err  output  1  sticky; issue while can_issue=0, or z_in_stb while in_flight=0.
nan_count  output  CNT_W  NaN results accepted (optional feature only).

Behaviour:
Reset:
- Clock and reset are fixed: single clock clk; reset rst is asynchronous and active-high.
- Asserting rst immediately clears wr_ptr, rd_ptr, count, in_flight, overflow, protocol_err and nan_count.
- Consequently m_valid=0, m_data=16'h0000 and can_issue=1.
- Storage array contents are not reset.
- Reset mid-operation discards all buffered and in-flight results. Any z_in_stb arriving after rst deasserts is treated as unsolicited (in_flight=0 case below).

Write and read:
- Write: on z_in_stb when count<DEPTH, mem[wr_ptr]<=z_in and wr_ptr increments, wrapping modulo DEPTH.
- Read: when m_valid && m_ready, rd_ptr increments, wrapping modulo DEPTH.
- m_valid = (count!=0). m_data = mem[rd_ptr] when m_valid, else 16'h0000.
- No write-to-read bypass: a word written into an empty FIFO is visible the following cycle. Write-to-m_valid latency is 1 cycle.
- Read and write in the same cycle: both pointers advance and count is unchanged. This applies when count=DEPTH too: the write is accepted and no overflow is flagged.
- Write at count=DEPTH without a simultaneous read: the word is dropped, overflow<=1, pointers unchanged.

Credit accounting:
- in_flight: +1 on issue, -1 on z_in_stb, unchanged when both occur.
- z_in_stb with in_flight=0: in_flight stays 0, protocol_err<=1, and the data is still written if there is space.
- can_issue = ((count + in_flight) < DEPTH), combinational from registered state only. It has no path from m_ready or issue.
- issue while can_issue=0: in_flight still increments, saturating at DEPTH, and protocol_err<=1.
- Guarantee: if the issuer respects can_issue, overflow never sets, independent of multiplier latency.

Sticky flags: overflow and protocol_err clear only on rst.

Optional Feature:
Macro MUL_RESULT_NAN_COUNT_EN.
- Defined: nan_count increments on every accepted write whose z_in[14:7]==8'hFF and z_in[6:0]!=0, saturating at 2^CNT_W-1. Dropped writes are not counted.
- Undefined: the nan_count port remains and is tied to 0. No counter logic is built.

Test Plan:
1. Reset -> issue pulse -> z_in=16'h40C0 (6.0) with z_in_stb 3 cycles later: in_flight goes 1 then 0. Next cycle m_valid=1, m_data=16'h40C0, count=1. With m_ready=1, following cycle m_valid=0, m_data=16'h0000.
2. DEPTH=8, m_ready=0, issue every cycle: can_issue drops after 8 issues. Results 16'h3F80,16'h4000,... arrive in order and fill count=8. overflow stays 0. Drain order matches write order across the pointer wrap.
3. count=8, simultaneous z_in_stb (16'h4040) and m_ready=1: count stays 8, overflow=0, 16'h4040 is read last.
4. count=8, m_ready=0, forced z_in_stb with in_flight=0: word dropped, overflow=1, protocol_err=1, count=8.
5. Same-cycle issue and z_in_stb at in_flight=2: in_flight stays 2. Assert rst asynchronously between clock edges: all outputs clear immediately, can_issue=1.
6. With MUL_RESULT_NAN_COUNT_EN defined, write 16'hFFC0, 16'h7F80 (inf), 16'hFFC0: nan_count=2. Without the macro, nan_count stays 0.
